memory_array: RTL and testbench
===============================

# memory_array

Parametrised single-port synchronous RAM for the 6502 system memory map, replacing the fixed primitive-based block. It adds:
- configurable storage depth, with address mirroring
- selectable read latency
- selectable read-during-write behaviour
- a write-protected ROM window
- a hardware zero-fill sequence after reset

It sits between the CPU bus interface and the rest of the system. Storage is inferred RTL; there is no vendor macro.

## Interface
- DATA_WIDTH, 8, data word width in bits.
- ADDR_WIDTH, 16, width of the bus address.
- DEPTH_LOG2, 12, log2 of stored words; legal range 1..ADDR_WIDTH. Address bits above DEPTH_LOG2 are ignored (mirroring).
- READ_LATENCY, 1, read latency; 1 or 2 cycles only.
- WRITE_MODE, 0, read-during-write behaviour: 0 = WRITE_FIRST, 1 = READ_FIRST, 2 = NO_CHANGE.
- ROM_ENABLE, 0, 1 enables write protection of the ROM window.
- ROM_BASE, 'hE000, first protected address (compared on the full ADDR_WIDTH address). The window runs from ROM_BASE to the all-ones address.
- CLEAR_ON_RESET, 1, 1 zero-fills storage after reset.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_enable  in  1  read request this cycle.
- wr_enable  in  1  write request this cycle.
- addr  in  ADDR_WIDTH  word address.
- wr_data  in  DATA_WIDTH  write data.
- rd_data  out  DATA_WIDTH  read data; holds its value between reads.
- rd_valid  out  1  one-cycle pulse marking new rd_data.
- busy  out  1  clear sequence in progress; requests are ignored while high.
- wr_error  out  1  one-cycle pulse for a rejected write.

## Operation
- Reset values: rd_data = 0, rd_valid = 0, wr_error = 0, busy = CLEAR_ON_RESET.
- Reset flushes the read pipeline. Stored contents are untouched by reset itself.
- State machine has two states, CLEAR and READY.
  - Reset enters CLEAR if CLEAR_ON_RESET = 1, otherwise READY. Reset sets clr_addr to 0.
  - CLEAR: each non-reset cycle writes 0 to mem[clr_addr] and increments clr_addr.
  - When clr_addr = 2^DEPTH_LOG2 - 1 has been written, the next state is READY and busy drops.
  - busy is high in every CLEAR cycle. It stays high while reset is held, then for exactly 2^DEPTH_LOG2 cycles after reset is released.
- Storage index is addr[DEPTH_LOG2-1:0].
- A write is accepted when wr_enable = 1, state is READY, and not (ROM_ENABLE = 1 and addr >= ROM_BASE).
- Rejected write: wr_enable = 1 while in CLEAR, or a protected write. Storage is unchanged and wr_error pulses on the next cycle.
  - wr_error is never asserted during reset.
  - A wr_enable in a reset cycle is simply dropped.
- A read is accepted when rd_enable = 1 and state is READY. rd_enable while busy is dropped silently and produces no rd_valid.
- Simultaneous read and write at the same address, per WRITE_MODE:
  - WRITE_FIRST: rd_data returns wr_data.
  - READ_FIRST: rd_data returns the old contents.
  - NO_CHANGE: the write occurs, the read is suppressed (no rd_valid), and rd_data holds.
- Simultaneous read and rejected write: the read proceeds normally with old data in every mode, and wr_error pulses.
- rd_data changes only together with rd_valid, or on reset.

## Timing
- Read accepted at cycle t: rd_data is valid and rd_valid = 1 at cycle t + READ_LATENCY.
- The read pipeline is fully pipelined: back-to-back reads give back-to-back rd_valid with no bubbles.
- A write accepted at cycle t is visible to a read accepted at cycle t+1.
- With READ_LATENCY = 2, a write at t+1 does not alter the result of a read accepted at t.
- Reset asserted mid-pipeline: rd_valid = 0 from the next cycle, and in-flight reads are discarded.
- Reset asserted mid-CLEAR restarts the sweep at address 0.
- wr_error is registered: it is high in cycle t+1 for a rejected write at t.

## Test plan
- Reset with DEPTH_LOG2 = 4, CLEAR_ON_RESET = 1 (memory preloaded non-zero), release at cycle 0 -> busy = 1 for cycles 0..15, 0 at cycle 16; reads of all 16 addresses return 'h00.
- READY, READ_LATENCY = 2: write 'hA5 to 'h0003, then read 'h0003, 'h0013, 'hFFF3 on consecutive cycles -> three consecutive rd_valid pulses, each with 'hA5 (mirroring).
- WRITE_MODE swept 0/1/2, location holds 'h11, simultaneous rd+wr of 'h22 -> rd_data 'h22 with rd_valid / 'h11 with rd_valid / no rd_valid and rd_data held; location reads 'h22 afterwards in all three modes.
- ROM_ENABLE = 1, ROM_BASE = 'hE000: write 'h55 to 'hE000 and to 'hDFFF -> wr_error pulse for 'hE000 only; reading 'hDFFF returns 'h55; 'hE000 returns its prior value.
- wr_enable and rd_enable during busy -> no storage change, no rd_valid, a wr_error pulse per write.
- Reset asserted one cycle after a READ_LATENCY = 2 read -> no rd_valid appears; rd_data = 0; the clear sequence restarts from address 0.

Source files
------------

// File: rtl/memory_array.sv
`default_nettype none
// ============================================================================
// Module      : memory_array
// Description : Single-port synchronous RAM with address mirroring, 1/2-cycle
//               read latency, read-during-write modes, ROM window protection
//               and a post-reset zero-fill sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_array #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 16,
    parameter int                    DEPTH_LOG2     = 12,
    parameter int                    READ_LATENCY   = 1,
    parameter int                    WRITE_MODE     = 0,
    parameter int                    ROM_ENABLE     = 0,
    parameter logic [ADDR_WIDTH-1:0] ROM_BASE       = 'hE000,
    parameter int                    CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_enable,
    input  logic                  wr_enable,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  wr_error
);

    localparam int                    c_DEPTH    = 1 << DEPTH_LOG2;
    localparam int                    c_WF       = 0;
    localparam int                    c_NC       = 2;
    localparam logic [DEPTH_LOG2-1:0] c_CLR_ONE  = 1;
    localparam logic [DEPTH_LOG2-1:0] c_CLR_LAST = '1;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_busy;
    logic [DEPTH_LOG2-1:0] r_clr_addr;
    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_ready;
    logic                  w_protected;
    logic                  w_wr_accept;
    logic                  w_wr_reject;
    logic                  w_rd_accept;
    logic                  w_clearing;
    logic [DATA_WIDTH-1:0] w_rd_word;

    assign w_idx       = addr[DEPTH_LOG2-1:0];
    assign w_ready     = (r_state == ST_READY) && !reset;
    assign w_protected = (ROM_ENABLE != 0) && (addr >= ROM_BASE);
    assign w_wr_accept = wr_enable && w_ready && !w_protected;
    // Requests arriving in a reset cycle are dropped without an error pulse.
    assign w_wr_reject = wr_enable && !reset && !w_wr_accept;
    assign w_rd_accept = rd_enable && w_ready &&
                         !((WRITE_MODE == c_NC) && w_wr_accept);
    assign w_clearing  = (r_state == ST_CLEAR) && !reset;
    // Only an accepted write is forwarded; a rejected write leaves old data.
    assign w_rd_word   = ((WRITE_MODE == c_WF) && w_wr_accept) ? wr_data
                                                                : r_mem[w_idx];

    always_ff @(posedge clk) begin
        if (w_clearing) begin
            r_mem[r_clr_addr] <= '0;
        end else if (w_wr_accept) begin
            r_mem[w_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            r_busy     <= (CLEAR_ON_RESET != 0);
            r_clr_addr <= '0;
            wr_error   <= 1'b0;
        end else begin
            wr_error <= w_wr_reject;
            if (r_state == ST_CLEAR) begin
                r_clr_addr <= r_clr_addr + c_CLR_ONE;
                if (r_clr_addr == c_CLR_LAST) begin
                    r_state <= ST_READY;
                    r_busy  <= 1'b0;
                end
            end
        end
    end

    assign busy = r_busy;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  r_s1_valid;
            logic [DATA_WIDTH-1:0] r_s1_data;

            // Data is captured at acceptance, so a later write cannot alter it.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_s1_valid <= 1'b0;
                    r_s1_data  <= '0;
                    rd_valid   <= 1'b0;
                    rd_data    <= '0;
                end else begin
                    r_s1_valid <= w_rd_accept;
                    if (w_rd_accept) begin
                        r_s1_data <= w_rd_word;
                    end
                    rd_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        rd_data <= r_s1_data;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                end else begin
                    rd_valid <= w_rd_accept;
                    if (w_rd_accept) begin
                        rd_data <= w_rd_word;
                    end
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_memory_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_array
// Description : Directed bench for memory_array: four instances (latency 2 in
//               each write mode, plus latency 1) driven from one stimulus bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_array;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_enable = 1'b0;
    logic        wr_enable = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  wr_data = '0;

    logic [7:0]  dat [4];
    logic [3:0]  vld;
    logic [3:0]  bsy;
    logic [3:0]  err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Index 0..2: latency 2 with WRITE_FIRST / READ_FIRST / NO_CHANGE; 3: latency 1 WRITE_FIRST.
    memory_array #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .DEPTH_LOG2(4), .READ_LATENCY(2),
                   .WRITE_MODE(0), .ROM_ENABLE(1), .ROM_BASE(16'hE000), .CLEAR_ON_RESET(1))
    u_wf (.clk(clk), .reset(reset), .rd_enable(rd_enable), .wr_enable(wr_enable),
          .addr(addr), .wr_data(wr_data), .rd_data(dat[0]), .rd_valid(vld[0]),
          .busy(bsy[0]), .wr_error(err[0]));

    memory_array #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .DEPTH_LOG2(4), .READ_LATENCY(2),
                   .WRITE_MODE(1), .ROM_ENABLE(1), .ROM_BASE(16'hE000), .CLEAR_ON_RESET(1))
    u_rf (.clk(clk), .reset(reset), .rd_enable(rd_enable), .wr_enable(wr_enable),
          .addr(addr), .wr_data(wr_data), .rd_data(dat[1]), .rd_valid(vld[1]),
          .busy(bsy[1]), .wr_error(err[1]));

    memory_array #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .DEPTH_LOG2(4), .READ_LATENCY(2),
                   .WRITE_MODE(2), .ROM_ENABLE(1), .ROM_BASE(16'hE000), .CLEAR_ON_RESET(1))
    u_nc (.clk(clk), .reset(reset), .rd_enable(rd_enable), .wr_enable(wr_enable),
          .addr(addr), .wr_data(wr_data), .rd_data(dat[2]), .rd_valid(vld[2]),
          .busy(bsy[2]), .wr_error(err[2]));

    memory_array #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .DEPTH_LOG2(4), .READ_LATENCY(1),
                   .WRITE_MODE(0), .ROM_ENABLE(1), .ROM_BASE(16'hE000), .CLEAR_ON_RESET(1))
    u_l1 (.clk(clk), .reset(reset), .rd_enable(rd_enable), .wr_enable(wr_enable),
          .addr(addr), .wr_data(wr_data), .rd_data(dat[3]), .rd_valid(vld[3]),
          .busy(bsy[3]), .wr_error(err[3]));

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] a;
        logic [7:0]  d;
        logic        v2;   // expected latency-2 WRITE_FIRST valid / data
        logic [7:0]  d2;
        logic        v1;   // expected latency-1 valid / data
        logic [7:0]  d1;
        logic        e;    // expected wr_error
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs; returns 1 time unit after the rising edge.
    task automatic cyc(input logic i_r, input logic i_w, input logic [15:0] i_a,
                       input logic [7:0] i_d);
        rd_enable = i_r;
        wr_enable = i_w;
        addr      = i_a;
        wr_data   = i_d;
        @(posedge clk);
        #1;
    endtask

    task automatic rd_check(input logic [15:0] i_a, input logic [7:0] i_exp);
        cyc(1'b1, 1'b0, i_a, 8'h00);
        chk($sformatf("l1 rd_valid @%h", i_a), vld[3], 1);
        chk($sformatf("l1 rd_data @%h", i_a), dat[3], i_exp);
        cyc(1'b0, 1'b0, 16'h0000, 8'h00);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("lat2[%0d] rd_valid @%h", k, i_a), vld[k], 1);
            chk($sformatf("lat2[%0d] rd_data @%h", k, i_a), dat[k], i_exp);
        end
    endtask

    // Called with reset just released: expects exactly 16 busy cycles.
    task automatic wait_clear(input logic inject);
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("busy[%0d] c%0d", k, i), bsy[k], 1);
                chk($sformatf("rd_valid busy[%0d] c%0d", k, i), vld[k], 0);
                chk($sformatf("wr_error busy[%0d] c%0d", k, i), err[k],
                    {31'd0, inject && (i == 9)});
            end
            if (inject && i == 8)      cyc(1'b0, 1'b1, 16'h0002, 8'hEE);
            else if (inject && i == 9) cyc(1'b1, 1'b0, 16'h0002, 8'h00);
            else                       cyc(1'b0, 1'b0, 16'h0000, 8'h00);
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("busy done[%0d]", k), bsy[k], 0);
            chk($sformatf("rd_valid done[%0d]", k), vld[k], 0);
            chk($sformatf("wr_error done[%0d]", k), err[k], 0);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 16'h0003, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 16'h0003, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 16'h0013, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 16'hFFF3, 8'h00, 1'b1, 8'hA5, 1'b1, 8'hA5, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 16'hE000, 8'h55, 1'b1, 8'hA5, 1'b1, 8'hA5, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 16'hDFFF, 8'h55, 1'b1, 8'hA5, 1'b0, 8'hA5, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 16'hDFFF, 8'h00, 1'b0, 8'hA5, 1'b0, 8'hA5, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 16'hE000, 8'h00, 1'b0, 8'hA5, 1'b1, 8'h55, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 16'hE000, 8'h77, 1'b1, 8'h55, 1'b1, 8'h00, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 16'h0005, 8'h3C, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 16'h0005, 8'h00, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 16'h0005, 8'h99, 1'b1, 8'h3C, 1'b1, 8'h3C, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h3C, 1'b0, 8'h3C, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 16'h0005, 8'h00, 1'b0, 8'h3C, 1'b0, 8'h3C, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h3C, 1'b1, 8'h99, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h99, 1'b0, 8'h99, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h99, 1'b0, 8'h99, 1'b0};

        // Reset values; a write during the last reset cycle must be dropped.
        reset = 1'b1;
        cyc(1'b0, 1'b0, 16'h0000, 8'h00);
        cyc(1'b0, 1'b0, 16'h0000, 8'h00);
        cyc(1'b0, 1'b1, 16'h0002, 8'h44);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset rd_data[%0d]", k), dat[k], 0);
            chk($sformatf("reset rd_valid[%0d]", k), vld[k], 0);
            chk($sformatf("reset wr_error[%0d]", k), err[k], 0);
            chk($sformatf("reset busy[%0d]", k), bsy[k], 1);
        end
        reset = 1'b0;
        wait_clear(1'b1);
        rd_check(16'h0002, 8'h00);

        // Fill with non-zero data, then reset twice (restart mid-sweep) and verify zero-fill.
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 16'(i), 8'(8'h80 + i));
        rd_check(16'h0007, 8'h87);
        rd_check(16'h001C, 8'h8C);
        reset = 1'b1;
        cyc(1'b0, 1'b0, 16'h0000, 8'h00);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 16'h0000, 8'h00);
        reset = 1'b1;
        cyc(1'b0, 1'b0, 16'h0000, 8'h00);
        reset = 1'b0;
        wait_clear(1'b0);
        for (int i = 0; i < 16; i++) rd_check(16'(i), 8'h00);
        cyc(1'b0, 1'b0, 16'h0000, 8'h00);

        // Mirroring, ROM protection, forwarding and write-after-read ordering.
        for (int r = 0; r < 19; r++) begin
            chk($sformatf("tbl%0d wf rd_valid", r), vld[0], tbl[r].v2);
            chk($sformatf("tbl%0d wf rd_data", r), dat[0], tbl[r].d2);
            chk($sformatf("tbl%0d l1 rd_valid", r), vld[3], tbl[r].v1);
            chk($sformatf("tbl%0d l1 rd_data", r), dat[3], tbl[r].d1);
            chk($sformatf("tbl%0d wr_error", r), err[0], tbl[r].e);
            chk($sformatf("tbl%0d l1 wr_error", r), err[3], tbl[r].e);
            cyc(tbl[r].rd, tbl[r].wr, tbl[r].a, tbl[r].d);
        end
        rd_check(16'h0000, 8'h00);

        // Read-during-write in each mode.
        cyc(1'b0, 1'b1, 16'h0009, 8'h11);
        cyc(1'b1, 1'b0, 16'h0009, 8'h00);
        cyc(1'b1, 1'b1, 16'h0009, 8'h22);
        chk("rdw l1 rd_valid", vld[3], 1);
        chk("rdw l1 rd_data", dat[3], 8'h22);
        for (int k = 0; k < 3; k++) chk($sformatf("rdw pre[%0d] rd_data", k), dat[k], 8'h11);
        cyc(1'b0, 1'b0, 16'h0000, 8'h00);
        chk("rdw wf rd_valid", vld[0], 1);
        chk("rdw wf rd_data", dat[0], 8'h22);
        chk("rdw rf rd_valid", vld[1], 1);
        chk("rdw rf rd_data", dat[1], 8'h11);
        chk("rdw nc rd_valid", vld[2], 0);
        chk("rdw nc rd_data", dat[2], 8'h11);
        rd_check(16'h0009, 8'h22);

        // Reset one cycle after a latency-2 read: read is discarded and sweep restarts.
        cyc(1'b1, 1'b0, 16'h0005, 8'h00);
        reset = 1'b1;
        cyc(1'b0, 1'b0, 16'h0000, 8'h00);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("midreset rd_valid[%0d]", k), vld[k], 0);
            chk($sformatf("midreset rd_data[%0d]", k), dat[k], 0);
            chk($sformatf("midreset busy[%0d]", k), bsy[k], 1);
        end
        reset = 1'b0;
        wait_clear(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
